half_dense_layer: RTL
=====================

# half_dense_layer

Parametrised, streaming half-precision (IEEE 754 binary16) fully-connected layer engine: computes y[o] = b[o] + Σ x[i]·W[i][o] for OUT_NODES outputs over IN_NODES inputs, LANES outputs in parallel per pass. Weights and biases arrive on a valid/ready stream rather than as full array ports, so one instance serves any layer of the MNIST predictor (784→50, 50→10) or larger networks. It sits between the input-vector buffer and the next layer or argmax stage.

## Interface
- IN_NODES, 784, input vector length (≥1)
- OUT_NODES, 50, output vector length (≥1)
- LANES, 10, parallel MAC lanes; GROUPS = ceil(OUT_NODES/LANES) passes
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; ignored while busy=1
- busy  out  1  high from cycle after accepted start until done pulse
- done  out  1  one-cycle pulse after final group handshake
- x_addr  out  $clog2(IN_NODES)  registered input-vector read index
- x_data  in  16  x[x_addr], combinational (same-cycle) read
- w_valid  in  1  weight/bias beat valid
- w_ready  out  1  weight/bias beat accepted when w_valid & w_ready
- w_data  in  16*LANES  lane l in bits [16l+15:16l]
- y_valid  out  1  group result valid, held until y_ready
- y_ready  in  1  group result consumed when y_valid & y_ready
- y_group  out  $clog2(GROUPS)+1  group index of y_data (outputs group*LANES .. +LANES-1)
- y_data  out  16*LANES  lane results, same packing as w_data

## Operation
- States: IDLE → BIAS → MAC → EMIT → (BIAS of next group | IDLE).
- IDLE: w_ready=0; start=1 → BIAS, busy=1, y_group=0, x_addr=0.
- BIAS: w_ready=1; accepted beat loads acc[l] ← w_data lane l; → MAC.
- MAC: w_ready=1; beat i (i=0..IN_NODES-1) for group g carries W[i][g*LANES+l]; acc[l] ← half_add(acc[l], half_mul(x_data, w_l)); x_addr increments on each accepted beat; after beat IN_NODES-1 → EMIT, x_addr ← 0.
- Arithmetic uses the team's combinational half-precision multiplier and adder (round-to-nearest-even); accumulation order is strictly i ascending.
- EMIT: w_ready=0; y_data registered from acc (activation applied, see Configuration); y_valid=1 until y_ready. On handshake: g < GROUPS-1 → y_group+1, BIAS; else → IDLE, done=1 one cycle, busy=0.
- Padded lanes (g*LANES+l ≥ OUT_NODES, last group only): still consume beats (data ignored), y_data lane forced 16'h0000.
- w_valid=0 stalls in place: no accumulator, x_addr or state change.
- Reset (any time, including mid-pass): abort, state IDLE; busy, done, w_ready, y_valid = 0; y_data, y_group, x_addr, acc = 0.

## Timing
- start sampled at edge 0; w_ready high in cycle after edge 0.
- Throughput one beat per cycle; no bubble between BIAS and MAC or between MAC beats.
- y_valid rises the cycle after the last MAC beat is accepted (1-cycle latency).
- No overlap: next group's bias beat cannot be accepted in the same cycle as y handshake; w_ready rises the cycle after.
- With w_valid and y_ready held high: each group spans IN_NODES+2 edges; done high in the cycle after edge GROUPS·(IN_NODES+2).
- start asserted coincident with done or while busy: ignored.

## Configuration
- HALF_DENSE_RELU_EN defined: EMIT applies ReLU; any acc with bit 15 set (negatives, −0, negative-sign NaN) outputs 16'h0000, others pass unchanged.
- Undefined: linear output, y_data = acc bit-exact.

## Test plan
- IN_NODES=4, OUT_NODES=3, LANES=2; x=3C00 ×4, bias 0000, weights 3800 → group 0 y_data lanes 4000/4000, group 1 lanes 4000/0000 (padded), done at edge 13 after start.
- Same, bias 3C00, weights 3400 → every real lane 4000.
- Weights B800, bias 0000 → lanes C000 without HALF_DENSE_RELU_EN, 0000 with it.
- Random w_valid gaps and y_ready held low 5 cycles in EMIT → identical results, y_valid/y_data stable while stalled, no beats accepted in EMIT.
- rstn pulsed low mid-MAC of group 1 → all outputs to reset values immediately; fresh start then produces correct results from group 0.
- start pulsed while busy and on done cycle → ignored; default 784/50/10 with MNIST image 0 layer-1 weights matches software half model bit-exact.

Source files
------------

// File: rtl/half_dense_layer.sv
// Streaming binary16 fully-connected layer: y[o] = b[o] + sum_i x[i]*W[i][o], LANES outputs per pass.
// Define HALF_DENSE_RELU_EN to apply ReLU to emitted results; default build is linear.
`timescale 1ns/1ps

module half_dense_layer #(
    parameter int IN_NODES  = 784,
    parameter int OUT_NODES = 50,
    parameter int LANES     = 10,
    localparam int GROUPS   = (OUT_NODES + LANES - 1) / LANES,
    localparam int XW       = (IN_NODES > 1) ? $clog2(IN_NODES) : 1,
    localparam int GW       = $clog2(GROUPS) + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [XW-1:0]         x_addr,
    input  logic [15:0]           x_data,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [16*LANES-1:0]   w_data,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic [GW-1:0]         y_group,
    output logic [16*LANES-1:0]   y_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BIAS = 2'd1;
    localparam logic [1:0] ST_MAC  = 2'd2;
    localparam logic [1:0] ST_EMIT = 2'd3;

    localparam logic [15:0] QNAN = 16'h7e00;

    // Rounds value = mant * 2^exp to binary16, round-to-nearest-even, with subnormals and overflow.
    function automatic logic [15:0] round_pack(input logic sign, input int exp,
                                               input logic [41:0] mant);
        int          p;
        int          q;
        int          s;
        int          enc;
        logic [41:0] r;
        logic        guard;
        logic        sticky;
        if (mant == 42'd0) return {sign, 15'h0000};
        p = 0;
        for (int i = 0; i < 42; i++) begin
            if (mant[i]) p = i;
        end
        q = p + exp - 10;
        if (q < -24) q = -24;
        s = q - exp;
        if (s <= 0) begin
            r      = mant << (-s);
            guard  = 1'b0;
            sticky = 1'b0;
        end else begin
            r      = mant >> s;
            guard  = mant[s-1];
            sticky = |(mant & ((42'd1 << (s - 1)) - 42'd1));
        end
        if (guard && (sticky || r[0])) r = r + 42'd1;
        // Hidden bit in r carries into the exponent field naturally.
        enc = ((q + 24) << 10) + int'(r[15:0]);
        if (enc >= 31744) return {sign, 15'h7c00};
        return {sign, enc[14:0]};
    endfunction

    function automatic logic [15:0] half_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        logic [10:0] ma, mb;
        int          ea, eb;
        logic [21:0] prod;
        s      = a[15] ^ b[15];
        nan_a  = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
        nan_b  = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
        inf_a  = (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
        inf_b  = (b[14:10] == 5'h1f) && (b[9:0] == 10'd0);
        zero_a = (a[14:0] == 15'd0);
        zero_b = (b[14:0] == 15'd0);
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) return QNAN;
        if (inf_a || inf_b) return {s, 15'h7c00};
        ma   = {(a[14:10] != 5'd0), a[9:0]};
        mb   = {(b[14:10] != 5'd0), b[9:0]};
        ea   = (a[14:10] == 5'd0) ? 1 : int'(a[14:10]);
        eb   = (b[14:10] == 5'd0) ? 1 : int'(b[14:10]);
        prod = 22'(ma) * 22'(mb);
        return round_pack(s, ea + eb - 50, {20'd0, prod});
    endfunction

    // Operands are aligned exactly in units of 2^-24, so only one rounding step occurs.
    function automatic logic [15:0] half_add(input logic [15:0] a, input logic [15:0] b);
        logic        nan_a, nan_b, inf_a, inf_b;
        logic [41:0] va, vb, mag;
        logic        s;
        int          ea, eb;
        nan_a = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
        nan_b = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
        inf_a = (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
        inf_b = (b[14:10] == 5'h1f) && (b[9:0] == 10'd0);
        if (nan_a || nan_b || (inf_a && inf_b && (a[15] != b[15]))) return QNAN;
        if (inf_a) return a;
        if (inf_b) return b;
        ea = (a[14:10] == 5'd0) ? 1 : int'(a[14:10]);
        eb = (b[14:10] == 5'd0) ? 1 : int'(b[14:10]);
        va = {31'd0, (a[14:10] != 5'd0), a[9:0]} << (ea - 1);
        vb = {31'd0, (b[14:10] != 5'd0), b[9:0]} << (eb - 1);
        if (va >= vb) begin
            s   = a[15];
            mag = (a[15] == b[15]) ? va + vb : va - vb;
        end else begin
            s   = b[15];
            mag = (a[15] == b[15]) ? va + vb : vb - va;
        end
        if (mag == 42'd0) s = a[15] & b[15];
        return round_pack(s, -24, mag);
    endfunction

    function automatic logic [15:0] activate(input logic [15:0] v);
`ifdef HALF_DENSE_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    logic [1:0]  state;
    logic [15:0] acc     [LANES];
    logic [15:0] mac_sum [LANES];
    logic        lane_pad[LANES];
    logic        last_beat;
    logic        last_group;

    assign busy       = (state != ST_IDLE);
    assign w_ready    = (state == ST_BIAS) || (state == ST_MAC);
    assign y_valid    = (state == ST_EMIT);
    assign last_beat  = (x_addr == XW'(IN_NODES - 1));
    assign last_group = (y_group == GW'(GROUPS - 1));

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            mac_sum[l]  = half_add(acc[l], half_mul(x_data, w_data[16*l +: 16]));
            lane_pad[l] = (int'(y_group) * LANES + l) >= OUT_NODES;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            done    <= 1'b0;
            x_addr  <= '0;
            y_group <= '0;
            y_data  <= '0;
            for (int l = 0; l < LANES; l++) acc[l] <= 16'h0000;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A start landing on the done cycle belongs to the finished job.
                    if (start && !done) begin
                        state   <= ST_BIAS;
                        y_group <= '0;
                        x_addr  <= '0;
                    end
                end
                ST_BIAS: begin
                    if (w_valid) begin
                        for (int l = 0; l < LANES; l++) acc[l] <= w_data[16*l +: 16];
                        state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (w_valid) begin
                        for (int l = 0; l < LANES; l++) acc[l] <= mac_sum[l];
                        if (last_beat) begin
                            x_addr <= '0;
                            state  <= ST_EMIT;
                            for (int l = 0; l < LANES; l++) begin
                                y_data[16*l +: 16] <= lane_pad[l] ? 16'h0000
                                                                  : activate(mac_sum[l]);
                            end
                        end else begin
                            x_addr <= x_addr + XW'(1);
                        end
                    end
                end
                default: begin
                    if (y_ready) begin
                        if (last_group) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else begin
                            y_group <= y_group + GW'(1);
                            state   <= ST_BIAS;
                        end
                    end
                end
            endcase
        end
    end

endmodule
